// File: rtl/serve_sequencer_if.sv
// Serve sequencer bus: frame tick, game-state code and serve buttons in;
// puck load/enable controls, serve-complete request and debug phase out.
interface serve_sequencer_if;
  logic       vSyncStart;
  logic [7:0] state;
  logic       servePlayer;
  logic       serveComputer;
  logic       ballLoad;
  logic [9:0] ballLoadX;
  logic [9:0] ballLoadY;
  logic       ballDirRight;
  logic       ballEnable;
  logic       serveDone;
  logic [1:0] countdown;
  logic [2:0] phase;

  modport master (
    output vSyncStart, state, servePlayer, serveComputer,
    input  ballLoad, ballLoadX, ballLoadY, ballDirRight, ballEnable,
           serveDone, countdown, phase
  );

  modport slave (
    input  vSyncStart, state, servePlayer, serveComputer,
    output ballLoad, ballLoadX, ballLoadY, ballDirRight, ballEnable,
           serveDone, countdown, phase
  );
endinterface

// File: rtl/serve_sequencer.sv
// Air-hockey serve sequencer: park puck, wait for server, 3-2-1 countdown, launch.
// Define SERVE_AUTO_EN to build the ARMED auto-serve timeout.
module serve_sequencer #(
  parameter int         COUNTDOWN_FRAMES  = 60,
  parameter int         AUTO_SERVE_FRAMES = 300,
  parameter logic [9:0] CENTER_X          = 10'd320,
  parameter logic [9:0] CENTER_Y          = 10'd240
) (
  input logic             pixelClock,
  input logic             reset,
  serve_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_PARK         = 3'd1,
    S_WAIT_RELEASE = 3'd2,
    S_ARMED        = 3'd3,
    S_COUNTDOWN    = 3'd4,
    S_LAUNCH       = 3'd5,
    S_RUN          = 3'd6
  } state_t;

  localparam int FC_W = $clog2(COUNTDOWN_FRAMES + 1);
  localparam logic [FC_W-1:0] FRAME_LAST = FC_W'(COUNTDOWN_FRAMES - 1);

  state_t          r_state, w_state_next;
  logic [FC_W-1:0] r_frame, w_frame_next;
  logic [1:0]      r_digit, w_digit_next;
  logic            r_kick, w_kick_next;
  logic            r_dir, w_dir_next;
  logic            r_server_player, w_server_next;
  logic            r_ball_load, r_ball_enable, r_serve_done;
  logic [1:0]      r_countdown;
  logic            w_serve_btn;
  logic            w_auto_expired;

`ifdef SERVE_AUTO_EN
  localparam int AC_W = $clog2(AUTO_SERVE_FRAMES + 1);
  localparam logic [AC_W-1:0] AUTO_LAST = AC_W'(AUTO_SERVE_FRAMES - 1);
  logic [AC_W-1:0] r_auto, w_auto_next;
  assign w_auto_expired = (r_auto == AUTO_LAST);
`else
  assign w_auto_expired = 1'b0;
`endif

  // Only the conceding side's button is looked at.
  assign w_serve_btn = r_server_player ? bus.servePlayer : bus.serveComputer;

  always_comb begin
    w_state_next  = r_state;
    w_frame_next  = r_frame;
    w_digit_next  = r_digit;
    w_kick_next   = r_kick;
    w_dir_next    = r_dir;
    w_server_next = r_server_player;
`ifdef SERVE_AUTO_EN
    w_auto_next   = r_auto;
`endif
    if (bus.state == 8'd0 && r_state != S_IDLE) begin
      w_state_next = S_IDLE;
      w_frame_next = '0;
      w_digit_next = 2'd0;
      w_kick_next  = 1'b0;
`ifdef SERVE_AUTO_EN
      w_auto_next  = '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          case (bus.state)
            8'd1: begin
              w_dir_next   = 1'b1;
              w_kick_next  = 1'b1;
              w_state_next = S_PARK;
            end
            8'd2: begin
              w_server_next = 1'b0;
              w_dir_next    = 1'b0;
              w_state_next  = S_PARK;
            end
            8'd3: begin
              w_server_next = 1'b1;
              w_dir_next    = 1'b1;
              w_state_next  = S_PARK;
            end
            default: ;
          endcase
        end
        S_PARK: begin
          if (r_kick) begin
            w_state_next = S_COUNTDOWN;
            w_digit_next = 2'd3;
            w_frame_next = '0;
          end else begin
            w_state_next = S_WAIT_RELEASE;
          end
        end
        S_WAIT_RELEASE: begin
          if (bus.vSyncStart && !w_serve_btn) begin
            w_state_next = S_ARMED;
`ifdef SERVE_AUTO_EN
            w_auto_next  = '0;
`endif
          end
        end
        S_ARMED: begin
          // Press and timeout on the same tick collapse into one entry.
          if (bus.vSyncStart) begin
            if (w_serve_btn || w_auto_expired) begin
              w_state_next = S_COUNTDOWN;
              w_digit_next = 2'd3;
              w_frame_next = '0;
            end else begin
`ifdef SERVE_AUTO_EN
              w_auto_next = r_auto + 1'b1;
`endif
            end
          end
        end
        S_COUNTDOWN: begin
          if (bus.vSyncStart) begin
            if (r_frame == FRAME_LAST) begin
              w_frame_next = '0;
              if (r_digit == 2'd1) begin
                w_digit_next = 2'd0;
                w_state_next = S_LAUNCH;
              end else begin
                w_digit_next = r_digit - 2'd1;
              end
            end else begin
              w_frame_next = r_frame + 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          if (bus.state == 8'd1) begin
            w_state_next = S_RUN;
            w_kick_next  = 1'b0;
          end
        end
        S_RUN: begin
          if (bus.state != 8'd1) w_state_next = S_IDLE;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next-state values so they align with phase.
  always_ff @(posedge pixelClock) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_frame         <= '0;
      r_digit         <= 2'd0;
      r_kick          <= 1'b0;
      r_dir           <= 1'b0;
      r_server_player <= 1'b0;
      r_ball_load     <= 1'b0;
      r_ball_enable   <= 1'b0;
      r_serve_done    <= 1'b0;
      r_countdown     <= 2'd0;
`ifdef SERVE_AUTO_EN
      r_auto          <= '0;
`endif
    end else begin
      r_state         <= w_state_next;
      r_frame         <= w_frame_next;
      r_digit         <= w_digit_next;
      r_kick          <= w_kick_next;
      r_dir           <= w_dir_next;
      r_server_player <= w_server_next;
      r_ball_load     <= (w_state_next == S_PARK);
      r_ball_enable   <= (w_state_next == S_RUN);
      r_serve_done    <= (w_state_next == S_LAUNCH);
      r_countdown     <= (w_state_next == S_COUNTDOWN) ? w_digit_next : 2'd0;
`ifdef SERVE_AUTO_EN
      r_auto          <= w_auto_next;
`endif
    end
  end

  assign bus.ballLoad     = r_ball_load;
  assign bus.ballLoadX    = CENTER_X;
  assign bus.ballLoadY    = CENTER_Y;
  assign bus.ballDirRight = r_dir;
  assign bus.ballEnable   = r_ball_enable;
  assign bus.serveDone    = r_serve_done;
  assign bus.countdown    = r_countdown;
  assign bus.phase        = r_state;

endmodule

// File: doc/serve_sequencer.md
# serve_sequencer

Sequences every serve in the air-hockey game. It parks the puck at centre, waits for the conceding side to press serve (or times out), then runs a 3-2-1 countdown and releases the puck. It sits between the game-state FSM (score/phase codes) and the puck-motion datapath: it drives the puck load/enable controls and hands the "serve complete" request back to the game-state FSM.

## Interface
Parameters:
- COUNTDOWN_FRAMES, 60, frames per countdown digit (≥1)
- AUTO_SERVE_FRAMES, 300, frames in ARMED before forced serve (≥1)
- CENTER_X, 10'd320, puck park X
- CENTER_Y, 10'd240, puck park Y

Ports:
- pixelClock  in  1  sole clock
- reset  in  1  synchronous, active-high
- vSyncStart  in  1  one-cycle frame tick
- state  in  8  game-state code: 0 gameOver, 1 playing, 2 playerScored, 3 computerScored
- servePlayer  in  1  player serve button (level)
- serveComputer  in  1  computer-side serve button (level)
- ballLoad  out  1  one-cycle pulse: puck loads ballLoadX/Y
- ballLoadX  out  10  park X (constant CENTER_X)
- ballLoadY  out  10  park Y (constant CENTER_Y)
- ballDirRight  out  1  launch direction, 1 = toward computer (right)
- ballEnable  out  1  puck motion enable
- serveDone  out  1  level request to game-state FSM to enter playing
- countdown  out  2  displayed digit 3/2/1, 0 when not counting
- phase  out  3  current FSM state encoding (debug)

## Operation
- States (phase code): IDLE 0, PARK 1, WAIT_RELEASE 2, ARMED 3, COUNTDOWN 4, LAUNCH 5, RUN 6.
- IDLE: state==2 → server = computer, ballDirRight=0, go PARK. state==3 → server = player, ballDirRight=1, go PARK. state==1 → kickoff: ballDirRight=1, kick flag set, go PARK. state==0 → stay.
- PARK: ballLoad=1 for exactly this cycle. Next: kick ? COUNTDOWN : WAIT_RELEASE.
- WAIT_RELEASE: on vSyncStart with the server's button low → ARMED, autoCount=0.
- ARMED: on vSyncStart, server button high → COUNTDOWN; otherwise autoCount++. Reaching AUTO_SERVE_FRAMES-1 → COUNTDOWN.
- COUNTDOWN: digit starts at 3, frameCount=0. On each vSyncStart frameCount++. At COUNTDOWN_FRAMES-1, frameCount→0 and digit--. Expiry of digit 1 → LAUNCH.
- LAUNCH: serveDone=1, held until state==1 is sampled, then RUN. The kick flag clears on leaving LAUNCH.
- RUN: ballEnable=1; state≠1 → IDLE.
- Abort: state==0 in any state except IDLE → IDLE next cycle. ballEnable, serveDone and countdown go 0, and the counters clear.
- Only the server's button matters; the other button is ignored.
- Counters saturate, with no wrap. autoCount and frameCount are each wide enough for their own parameter.

## Timing
- Reset values: phase=IDLE, ballLoad=0, ballEnable=0, serveDone=0, countdown=0, ballDirRight=0. Counters and kick flag are 0.
- All outputs are registered. Transitions driven by state are 1 cycle after sampling. Frame-driven transitions occur on the vSyncStart cycle.
- ballLoad rises the cycle after IDLE detects a scored/kickoff state.
- Countdown lasts exactly 3·COUNTDOWN_FRAMES vSyncStart ticks after entering COUNTDOWN.
- countdown is nonzero only in COUNTDOWN. ballEnable is 1 only in RUN.
- Simultaneous abort and any other transition: abort wins.
- A button press on the same tick as auto-serve expiry gives one entry to COUNTDOWN.
- Reset mid-serve returns to IDLE regardless of state. If state is still 2/3 after reset, the sequence restarts at PARK.

## Configuration
- SERVE_AUTO_EN defined: ARMED auto-serve timeout as above.
- SERVE_AUTO_EN undefined: autoCount is not built and ARMED waits indefinitely for the server button. All other behaviour is unchanged.

## Test plan
- Reset with state=0 → phase 0; all outputs 0 across 10 frames.
- COUNTDOWN_FRAMES=2, state 0→1 → PARK pulse, countdown 3,3,2,2,1,1 over 6 ticks, serveDone=1, then RUN with ballEnable=1, ballDirRight=1.
- state=2 with serveComputer held → remains WAIT_RELEASE. Release then press on later ticks → COUNTDOWN, ballDirRight=0; servePlayer toggling has no effect.
- SERVE_AUTO_EN, AUTO_SERVE_FRAMES=4, state=3, no buttons → COUNTDOWN on the 4th ARMED tick. Without the macro → still ARMED after 100 ticks.
- state forced to 0 during COUNTDOWN digit 2 → next cycle phase 0, countdown=0, serveDone=0.
- LAUNCH with state held at 3 for 5 cycles → serveDone stays 1, ballEnable 0. state→1 → RUN the next cycle.
